// File: rtl/tcs_scan_controller.sv
// ---------------------------------------------------------------------------
// tcs_scan_controller
// Sequencer for a TCS3200-class colour sensor. Steps the filter select
// through red, blue, clear, green; for each filter it waits a settle window
// and then counts sensor rising edges over a fixed gate window. The four
// counts and their saturation flags are published together after each scan.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   start         begin one scan (honoured in IDLE only)
//   cont          restart automatically after each scan (latched at scan start)
//   scale         frequency-scale value for S0/S1 (latched at scan start)
//   sensor        asynchronous sensor frequency output
//   s0s1, s2s3    scale pins / filter select (00 r, 01 b, 10 c, 11 g)
//   oe_n          sensor output enable, active low
//   cnt_r/b/c/g   counts of the last completed scan
//   ovf           saturation flags {g,c,b,r} of the last completed scan
//   busy          high while settling or gating
//   done          one-cycle pulse when the result registers update
// ---------------------------------------------------------------------------
module tcs_scan_controller #(
    parameter int unsigned GATE_CYCLES   = 100000,
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic [1:0]       scale,
    input  logic             sensor,
    output logic [1:0]       s0s1,
    output logic [1:0]       s2s3,
    output logic             oe_n,
    output logic [CNT_W-1:0] cnt_r,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_g,
    output logic [3:0]       ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACC_MAX     = '1;
    localparam logic [1:0]       CH_GREEN    = 2'b11;

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nxt;
    logic             cont_q;

    logic             sync1;
    logic             sync2;
    logic             sync_prev;
    logic             edge_p;

    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_sum;
    logic             acc_hit;
    logic             ovf_hit;
    logic [CNT_W-1:0] sh_r;
    logic [CNT_W-1:0] sh_b;
    logic [CNT_W-1:0] sh_c;
    logic [3:0]       ovf_sh;
    logic [3:0]       ovf_now;

    logic             busy_nxt;
    logic             oe_n_nxt;
    logic             done_nxt;
    logic             scan_begin;
    logic             in_gate;
    logic             gate_end;

    // Sensor synchroniser and rising-edge pulse (3 cycles of latency)
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
            edge_p    <= 1'b0;
        end else begin
            sync1     <= sensor;
            sync2     <= sync1;
            sync_prev <= sync2;
            edge_p    <= sync2 & ~sync_prev;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (tmr == SETTLE_LAST) state_nxt = GATE;
            GATE:    if (tmr == GATE_LAST) state_nxt = (s2s3 == CH_GREEN) ? DONE : SETTLE;
            DONE:    state_nxt = cont_q ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes and next values of the registered status outputs
    always_comb begin
        busy_nxt   = 1'b0;
        oe_n_nxt   = 1'b1;
        done_nxt   = 1'b0;
        tmr_nxt    = '0;
        scan_begin = 1'b0;
        in_gate    = 1'b0;
        gate_end   = 1'b0;

        busy_nxt   = (state_nxt == SETTLE) || (state_nxt == GATE);
        oe_n_nxt   = (state_nxt == IDLE);
        done_nxt   = (state_nxt == DONE);
        scan_begin = ((state == IDLE) && start) || ((state == DONE) && cont_q);
        in_gate    = (state == GATE);
        gate_end   = in_gate && (tmr == GATE_LAST);
        // Timer restarts on every state change so each window starts at 0
        if (((state == SETTLE) || (state == GATE)) && (state_nxt == state)) begin
            tmr_nxt = tmr + TMR_W'(1);
        end
    end

    // Saturating accumulator; ovf marks an edge that arrived at full scale
    always_comb begin
        acc_hit = in_gate && edge_p;
        ovf_hit = acc_hit && (acc == ACC_MAX);
        acc_sum = acc;
        if (acc_hit && !ovf_hit) begin
            acc_sum = acc + CNT_W'(1);
        end
        ovf_now = ovf_sh | (4'(ovf_hit) << s2s3);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr    <= '0;
            cont_q <= 1'b0;
            s0s1   <= 2'b00;
            s2s3   <= 2'b00;
            acc    <= '0;
            sh_r   <= '0;
            sh_b   <= '0;
            sh_c   <= '0;
            ovf_sh <= 4'b0000;
            cnt_r  <= '0;
            cnt_b  <= '0;
            cnt_c  <= '0;
            cnt_g  <= '0;
            ovf    <= 4'b0000;
            busy   <= 1'b0;
            oe_n   <= 1'b1;
            done   <= 1'b0;
        end else begin
            tmr  <= tmr_nxt;
            busy <= busy_nxt;
            oe_n <= oe_n_nxt;
            done <= done_nxt;

            if (scan_begin) begin
                s0s1   <= scale;
                cont_q <= cont;
                s2s3   <= 2'b00;
                acc    <= '0;
                ovf_sh <= 4'b0000;
            end else if (gate_end) begin
                acc    <= '0;
                ovf_sh <= ovf_now;
                unique case (s2s3)
                    2'b00:   sh_r <= acc_sum;
                    2'b01:   sh_b <= acc_sum;
                    2'b10:   sh_c <= acc_sum;
                    default: ;
                endcase
                if (s2s3 != CH_GREEN) begin
                    s2s3 <= s2s3 + 2'(1);
                end else begin
                    // Publish on entry to DONE so results coincide with the done pulse;
                    // green is taken straight from the accumulator
                    cnt_r <= sh_r;
                    cnt_b <= sh_b;
                    cnt_c <= sh_c;
                    cnt_g <= acc_sum;
                    ovf   <= ovf_now;
                end
            end else if (in_gate) begin
                acc    <= acc_sum;
                ovf_sh <= ovf_now;
            end
        end
    end

endmodule

// File: tb/tb_tcs_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_tcs_scan_controller
// Scoreboard bench: expected result sets are computed from the sensor
// periods and pushed when a scan is started; they are popped and compared
// whenever a controller pulses done.
// ---------------------------------------------------------------------------
module tb_tcs_scan_controller;

    localparam int unsigned G1 = 20;
    localparam int unsigned S1 = 4;
    localparam int unsigned W1 = 16;
    localparam int unsigned G2 = 40;
    localparam int unsigned S2 = 4;
    localparam int unsigned W2 = 4;

    typedef struct packed {
        logic [15:0] r;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] g;
        logic [3:0]  ovf;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic          cont;
    logic [1:0]    scale;
    logic          sensor = 1'b0;
    logic [1:0]    s0s1;
    logic [1:0]    s2s3;
    logic          oe_n;
    logic [W1-1:0] cnt_r, cnt_b, cnt_c, cnt_g;
    logic [3:0]    ovf;
    logic          busy;
    logic          done;

    logic          start2;
    logic          cont2;
    logic [1:0]    scale2;
    logic          sensor2 = 1'b0;
    logic [1:0]    s0s1_2;
    logic [1:0]    s2s3_2;
    logic          oe_n2;
    logic [W2-1:0] cnt_r2, cnt_b2, cnt_c2, cnt_g2;
    logic [3:0]    ovf2;
    logic          busy2;
    logic          done2;

    tcs_scan_controller #(.GATE_CYCLES(G1), .SETTLE_CYCLES(S1), .CNT_W(W1)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .scale(scale), .sensor(sensor),
        .s0s1(s0s1), .s2s3(s2s3), .oe_n(oe_n),
        .cnt_r(cnt_r), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_g(cnt_g),
        .ovf(ovf), .busy(busy), .done(done)
    );

    tcs_scan_controller #(.GATE_CYCLES(G2), .SETTLE_CYCLES(S2), .CNT_W(W2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .cont(cont2), .scale(scale2), .sensor(sensor2),
        .s0s1(s0s1_2), .s2s3(s2s3_2), .oe_n(oe_n2),
        .cnt_r(cnt_r2), .cnt_b(cnt_b2), .cnt_c(cnt_c2), .cnt_g(cnt_g2),
        .ovf(ovf2), .busy(busy2), .done(done2)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   c0 = 0;
    int   busy_first = -1;
    int   busy_last = -1;
    res_t q1[$];
    res_t q2[$];
    logic [1:0] h_s2s3 [512];
    logic       h_oe   [512];

    int   per [4];
    int   ph = 0;
    logic [1:0] last_ch = 2'b00;
    logic en2 = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected result set from per-filter sensor periods (0 = held low)
    function automatic res_t model(input int pr, input int pb, input int pc, input int pg,
                                   input int gate, input int w);
        res_t m;
        int   p [4];
        int   n;
        int   maxv;
        logic [15:0] v [4];
        m = '0;
        p[0] = pr; p[1] = pb; p[2] = pc; p[3] = pg;
        maxv = (1 << w) - 1;
        for (int i = 0; i < 4; i++) begin
            n = (p[i] == 0) ? 0 : gate / p[i];
            if (n > maxv) begin
                v[i] = 16'(maxv);
                m.ovf[i] = 1'b1;
            end else begin
                v[i] = 16'(n);
            end
        end
        m.r = v[0]; m.b = v[1]; m.c = v[2]; m.g = v[3];
        return m;
    endfunction

    // Sensor square wave whose period follows the selected filter
    always @(negedge clk) begin
        if (s2s3 !== last_ch) begin
            ph = 0;
            last_ch = s2s3;
        end
        if (per[s2s3] == 0) begin
            sensor = 1'b0;
        end else begin
            sensor = (ph < per[s2s3] / 2);
            ph = (ph + 1) % per[s2s3];
        end
    end

    always @(negedge clk) sensor2 = en2 ? ~sensor2 : 1'b0;

    // Scoreboard for the main instance
    always @(negedge clk) begin : mon1
        res_t e;
        if (done === 1'b1) begin
            if (q1.size() == 0) begin
                check("dut_unexpected_done", 1, 0);
            end else begin
                e = q1.pop_front();
                check("dut_cnt_r", cnt_r, e.r);
                check("dut_cnt_b", cnt_b, e.b);
                check("dut_cnt_c", cnt_c, e.c);
                check("dut_cnt_g", cnt_g, e.g);
                check("dut_ovf", ovf, e.ovf);
            end
        end
    end

    // Scoreboard for the narrow-counter instance
    always @(negedge clk) begin : mon2
        res_t e;
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("dut2_unexpected_done", 1, 0);
            end else begin
                e = q2.pop_front();
                check("dut2_cnt_r", cnt_r2, e.r);
                check("dut2_cnt_b", cnt_b2, e.b);
                check("dut2_cnt_c", cnt_c2, e.c);
                check("dut2_cnt_g", cnt_g2, e.g);
                check("dut2_ovf", ovf2, e.ovf);
            end
        end
    end

    task automatic sample();
        int rel;
        rel = cyc - c0;
        if (busy === 1'b1) begin
            if (busy_first < 0) busy_first = rel;
            busy_last = rel;
        end
        if (rel >= 0 && rel < 512) begin
            h_s2s3[rel] = s2s3;
            h_oe[rel]   = oe_n;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
    endtask

    task automatic kick(input logic [1:0] sc, input logic ct);
        @(negedge clk);
        scale = sc;
        cont = ct;
        start = 1'b1;
        c0 = cyc;
        busy_first = -1;
        busy_last = -1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done === 1'b1) begin
                at = cyc - c0;
                break;
            end
        end
        if (at < 0) check("wait_done_timeout", 0, 1);
    endtask

    task automatic run2(output int at);
        int base;
        @(negedge clk);
        start2 = 1'b1;
        base = cyc;
        @(negedge clk);
        start2 = 1'b0;
        at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done2 === 1'b1) begin
                at = cyc - base;
                break;
            end
        end
        if (at < 0) check("dut2_timeout", 0, 1);
    endtask

    initial begin
        int at;
        int d1;
        int d2;
        int rel;
        int s0s1_bad;
        int nbusy;
        int ndone;

        per = '{4, 4, 4, 4};
        rst = 1'b1; start = 1'b0; cont = 1'b0; scale = 2'b00;
        start2 = 1'b0; cont2 = 1'b0; scale2 = 2'b11;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        step();
        check("rst_cnt_r", cnt_r, 0);
        check("rst_cnt_g", cnt_g, 0);
        check("rst_ovf", ovf, 0);
        check("rst_s0s1", s0s1, 0);
        check("rst_s2s3", s2s3, 0);
        check("rst_oe_n", oe_n, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // Uniform period-4 wave: five edges per 20-cycle gate on every filter
        q1.push_back(model(4, 4, 4, 4, G1, W1));
        kick(2'b01, 1'b0);
        wait_done(200, at);
        check("t1_done_at", at, 97);
        check("t1_busy_first", busy_first, 1);
        check("t1_busy_last", busy_last, 96);
        check("t1_oe_n_scan", h_oe[2], 0);
        check("t1_s0s1", s0s1, 1);
        step();
        check("t1_done_pulse", done, 0);
        check("t1_busy_after", busy, 0);
        check("t1_oe_n_idle", oe_n, 1);

        // Distinct period per filter, green held low
        per = '{2, 4, 5, 0};
        q1.push_back(model(2, 4, 5, 0, G1, W1));
        kick(2'b00, 1'b0);
        wait_done(200, at);
        check("t2_done_at", at, 97);
        check("t2_sel_1", h_s2s3[1], 0);
        check("t2_sel_24", h_s2s3[24], 0);
        check("t2_sel_25", h_s2s3[25], 1);
        check("t2_sel_48", h_s2s3[48], 1);
        check("t2_sel_49", h_s2s3[49], 2);
        check("t2_sel_72", h_s2s3[72], 2);
        check("t2_sel_73", h_s2s3[73], 3);
        check("t2_sel_96", h_s2s3[96], 3);

        // Narrow counters saturate, then a quiet scan clears the flags
        en2 = 1'b1;
        q2.push_back(model(2, 2, 2, 2, G2, W2));
        run2(at);
        check("t3_done_at", at, 4 * (G2 + S2) + 1);
        en2 = 1'b0;
        repeat (10) @(negedge clk);
        q2.push_back(model(0, 0, 0, 0, G2, W2));
        run2(at);
        check("t3b_done_at", at, 4 * (G2 + S2) + 1);

        // Continuous mode: cont dropped mid-scan still yields one more scan
        per = '{4, 4, 4, 4};
        q1.push_back(model(4, 4, 4, 4, G1, W1));
        q1.push_back(model(4, 4, 4, 4, G1, W1));
        kick(2'b10, 1'b1);
        d1 = -1; d2 = -1; s0s1_bad = 0;
        for (int i = 0; i < 400 && d2 < 0; i++) begin
            step();
            rel = cyc - c0;
            if (rel == 50) cont = 1'b0;
            if (rel == 150) scale = 2'b01;
            if (s0s1 !== 2'b10) s0s1_bad++;
            if (done === 1'b1) begin
                if (d1 < 0) d1 = rel;
                else d2 = rel;
            end
        end
        check("t4_done1_at", d1, 97);
        check("t4_done2_at", d2, 194);
        check("t4_s0s1_held", s0s1_bad, 0);
        nbusy = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (busy === 1'b1) nbusy++;
        end
        check("t4_stays_idle", nbusy, 0);
        check("t4_oe_n_idle", oe_n, 1);

        // start during a scan is ignored
        q1.push_back(model(4, 4, 4, 4, G1, W1));
        kick(2'b00, 1'b0);
        d1 = -1;
        for (int i = 0; i < 200 && d1 < 0; i++) begin
            step();
            rel = cyc - c0;
            start = (rel == 30 || rel == 60);
            if (done === 1'b1) d1 = rel;
        end
        start = 1'b0;
        check("t5_done_at", d1, 97);
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy === 1'b1) nbusy++;
        end
        check("t5_no_restart", nbusy, 0);

        // Reset mid-scan discards the scan and clears results
        kick(2'b11, 1'b0);
        for (int i = 0; i < 59; i++) step();
        check("t6_busy_pre", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_oe_n", oe_n, 1);
        check("t6_done", done, 0);
        check("t6_cnt_r", cnt_r, 0);
        check("t6_cnt_b", cnt_b, 0);
        check("t6_cnt_c", cnt_c, 0);
        check("t6_cnt_g", cnt_g, 0);
        check("t6_ovf", ovf, 0);
        check("t6_s0s1", s0s1, 0);
        check("t6_s2s3", s2s3, 0);
        nbusy = 0; ndone = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) ndone++;
        end
        check("t6_idle_busy", nbusy, 0);
        check("t6_idle_done", ndone, 0);

        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
